// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry elastic buffer placed between two pipeline stages.
// Valid/ready on both sides, registered outputs (no input-to-output fall-through),
// synchronous flush that drops everything in flight, occupancy reporting and a
// saturating count of entries discarded by flush.
module pipe_stage_buf #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [CW-1:0]    occupancy,
   output logic [15:0]      discard_cnt
);

   // Registered control state
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [15:0]   r_discard_cnt;

   // Combinational helpers
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_push;
   logic             w_pop;
   logic [CW-1:0]    w_count_next;
   logic [16:0]      w_disc_sum;
   logic [15:0]      w_disc_next;
   logic [WIDTH-1:0] w_entry [DEPTH];

   // Acceptance looks only at stored count and flush, so a full buffer refuses
   // input even in a cycle where the head is being consumed.
   assign w_in_ready  = ~rst & ~flush & (r_count < CW'(DEPTH));
   assign w_out_valid = (r_count != '0);
   assign w_push      = in_valid  & w_in_ready  & ~flush;
   assign w_pop       = w_out_valid & out_ready & ~flush;

   // Everything a flush throws away: what is stored plus what is being offered.
   assign w_disc_sum  = {1'b0, r_discard_cnt} + 17'(r_count) + 17'(in_valid);

   // Next occupancy from push/pop; simultaneous push and pop leaves it unchanged
   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Clamp the discard total at all-ones instead of wrapping
   always_comb begin
      w_disc_next = w_disc_sum[15:0];
      if (w_disc_sum[16]) begin
         w_disc_next = 16'hFFFF;
      end
   end

   // Pointer, count and discard counter updates; flush outranks push and pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_discard_cnt <= '0;
      end else if (flush) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_discard_cnt <= w_disc_next;
      end else begin
         r_count <= w_count_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
      end
   end

   // One payload register per slot; contents survive flush and reset because
   // out_valid masks stale data.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] r_data;

         // Capture the offered payload when this slot is the write target
         always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == PW'(gi))) begin
               r_data <= in_data;
            end
         end

         assign w_entry[gi] = r_data;
      end
   endgenerate

   // Head entry, forced to zero whenever nothing is stored
   always_comb begin
      out_data = '0;
      if (w_out_valid) begin
         out_data = w_entry[r_rd_ptr];
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = w_out_valid;
   assign occupancy   = r_count;
   assign discard_cnt = r_discard_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=4 instance share one stimulus
// stream; each is compared every cycle against a queue-based reference model.
module tb_pipe_stage_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;
   logic        flush;

   logic        a_in_ready, a_out_valid;
   logic [63:0] a_out_data;
   logic [1:0]  a_occ;
   logic [15:0] a_disc;

   logic        b_in_ready, b_out_valid;
   logic [63:0] b_out_data;
   logic [2:0]  b_occ;
   logic [15:0] b_disc;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [63:0] q2 [$];
   logic [63:0] q4 [$];
   int          disc2 = 0;
   int          disc4 = 0;

   // Order tracking for the DEPTH=4 wrap-around run
   bit          track = 1'b0;
   logic [63:0] pushed [$];
   logic [63:0] popped [$];

   pipe_stage_buf #(.WIDTH(64), .DEPTH(2)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .flush(flush), .occupancy(a_occ), .discard_cnt(a_disc)
   );

   pipe_stage_buf #(.WIDTH(64), .DEPTH(4)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .flush(flush), .occupancy(b_occ), .discard_cnt(b_disc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_dut(input string nm, input int depth, input logic [63:0] q [$],
                          input int disc, input logic ir, input logic ov,
                          input logic [63:0] od, input int occ, input logic [15:0] dc);
      logic        exp_ir;
      logic [63:0] exp_od;
      exp_ir = !rst && !flush && (q.size() < depth);
      exp_od = (q.size() > 0) ? q[0] : 64'h0;
      chk({nm, "_in_ready"},    64'(ir),  64'(exp_ir));
      chk({nm, "_out_valid"},   64'(ov),  64'(q.size() > 0));
      chk({nm, "_out_data"},    od,       exp_od);
      chk({nm, "_occupancy"},   64'(occ), 64'(q.size()));
      chk({nm, "_discard_cnt"}, 64'(dc),  64'(disc));
   endtask

   task automatic chk_all();
      chk_dut("d2", 2, q2, disc2, a_in_ready, a_out_valid, a_out_data, int'(a_occ), a_disc);
      chk_dut("d4", 4, q4, disc4, b_in_ready, b_out_valid, b_out_data, int'(b_occ), b_disc);
   endtask

   // Behaviour at one rising edge: flush drops everything, otherwise FIFO with
   // acceptance judged on the occupancy before the edge.
   task automatic model_edge(input int depth, inout logic [63:0] q [$], inout int disc);
      int n;
      n = q.size();
      if (flush) begin
         disc = disc + n + (in_valid ? 1 : 0);
         if (disc > 65535) disc = 65535;
         q.delete();
      end else begin
         if (n > 0 && out_ready) void'(q.pop_front());
         if (in_valid && n < depth) q.push_back(in_data);
      end
   endtask

   task automatic edge_models();
      if (track && in_valid && !flush && q4.size() < 4) pushed.push_back(in_data);
      model_edge(2, q2, disc2);
      model_edge(4, q4, disc4);
   endtask

   // One cycle: drive, check at the falling edge, advance the model at the rising edge
   task automatic step(input logic v, input logic [63:0] d, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(negedge clk);
      chk_all();
      if (track && b_out_valid && out_ready && !flush) popped.push_back(b_out_data);
      @(posedge clk);
      edge_models();
      #1;
   endtask

   localparam logic [63:0] VA = 64'h0000_1000_AAAA_0001;
   localparam logic [63:0] VB = 64'h0000_1004_BBBB_0002;
   localparam logic [63:0] VC = 64'h0000_1008_CCCC_0003;
   localparam logic [63:0] VD = 64'h0000_2000_DDDD_0004;
   localparam logic [63:0] VE = 64'h0000_100C_EEEE_0005;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all();
      @(posedge clk);
      #1 rst = 1'b0;

      // Streaming through DEPTH=2 with the consumer always ready
      for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      // Stall and fill, then release
      step(1'b1, VA, 1'b0, 1'b0);
      step(1'b1, VB, 1'b0, 1'b0);
      step(1'b1, VC, 1'b0, 1'b0);
      chk("stall_head_d2", a_out_data, VA);
      chk("stall_occ_d2", 64'(a_occ), 64'd2);
      step(1'b1, VC, 1'b1, 1'b0);
      step(1'b1, VC, 1'b1, 1'b0);
      repeat (4) step(1'b0, '0, 1'b1, 1'b0);

      // Flush while full with a new offer pending
      step(1'b1, VA, 1'b0, 1'b0);
      step(1'b1, VB, 1'b0, 1'b0);
      step(1'b1, VE, 1'b0, 1'b1);
      chk("flush_disc_d2", 64'(a_disc), 64'd3);
      chk("flush_valid_d2", 64'(a_out_valid), 64'd0);
      step(1'b1, VD, 1'b0, 1'b0);
      chk("after_flush_head_d2", a_out_data, VD);
      step(1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a cycle with an entry stored
      step(1'b1, 64'h55, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      q2.delete(); q4.delete(); disc2 = 0; disc4 = 0;
      chk_all();
      @(posedge clk);
      #1 rst = 1'b0;
      step(1'b0, '0, 1'b0, 1'b0);

      // Random traffic: 13 entries through DEPTH=4 with random back-pressure
      track = 1'b1;
      pushed.delete(); popped.delete();
      for (int c = 0; c < 600 && !(pushed.size() == 13 && q4.size() == 0); c++) begin
         step((pushed.size() < 13) ? 1'($urandom_range(0, 1)) : 1'b0,
              {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      end
      track = 1'b0;
      chk("wrap_pop_count", 64'(popped.size()), 64'd13);
      for (int i = 0; i < 13 && i < popped.size(); i++) begin
         chk($sformatf("wrap_order_%0d", i), popped[i], pushed[i]);
      end

      // Saturation of the discard counter: one dropped offer per flush edge
      in_valid = 1'b1; in_data = '0; out_ready = 1'b0; flush = 1'b1;
      for (int c = 0; c < 70000 && disc2 < 65534; c++) begin
         @(posedge clk);
         edge_models();
      end
      #1;
      step(1'b1, '0, 1'b0, 1'b1);
      step(1'b1, '0, 1'b0, 1'b1);
      step(1'b1, '0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0);
      chk("sat_d2", 64'(a_disc), 64'hFFFF);
      chk("sat_d4", 64'(b_disc), 64'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
